// File: rtl/ecg_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ecg_frame_sequencer
//  Description : Collects parsed UART samples into the sample buffer, starts
//                the inference core once a full frame is loaded, waits for the
//                result and reports the class as one ASCII digit plus LF.
//                Optional macro LOAD_TIMEOUT_EN discards a stalled partial
//                frame after TIMEOUT_CYCLES idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module ecg_frame_sequencer #(
    parameter int DATA_W         = 16,
    parameter int NUM_SAMPLES    = 187,
    parameter int ADDR_W         = 8,
    parameter int CLASS_W        = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Num_valid,
    input  logic [DATA_W-1:0]  Num_data,
    output logic               Mem_we,
    output logic [ADDR_W-1:0]  Mem_addr,
    output logic [DATA_W-1:0]  Mem_wdata,
    output logic               Infer_start,
    input  logic               Infer_done,
    input  logic [CLASS_W-1:0] Infer_class,
    output logic               Tx_start,
    output logic [7:0]         Tx_byte,
    input  logic               Tx_done,
    output logic               Busy,
    output logic               Overrun,
    output logic [15:0]        Frame_count
);

    typedef enum logic [2:0] {
        S_LOAD       = 3'd0,
        S_START      = 3'd1,
        S_WAIT_INFER = 3'd2,
        S_TX_DIGIT   = 3'd3,
        S_TX_LF      = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [7:0]        c_ASCII_0  = 8'h30;
    localparam logic [7:0]        c_ASCII_Q  = 8'h3F;
    localparam logic [7:0]        c_ASCII_LF = 8'h0A;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_index;
    logic [CLASS_W-1:0]  r_class;
    logic                r_digit_sent;

    logic [7:0]          w_class8;
    logic [7:0]          w_digit;
    logic                w_tmo_hit;

    // ASCII encoding of the latched class; anything outside 0..9 reports '?'
    always_comb begin
        w_class8 = 8'(r_class);
        w_digit  = (w_class8 > 8'd9) ? c_ASCII_Q : (c_ASCII_0 + w_class8);
    end

`ifdef LOAD_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Idle detector for a partially loaded frame
    always_comb begin
        w_tmo_hit = (r_state == S_LOAD) && (r_index != '0) && !Num_valid &&
                    (r_tmo_cnt == c_TMO_LAST);
    end

    // Idle counter runs only while a partial frame sits in LOAD
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_tmo_cnt <= '0;
        end else if ((r_state != S_LOAD) || (r_index == '0) || Num_valid || w_tmo_hit) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    // Partial frames wait indefinitely
    always_comb begin
        w_tmo_hit = 1'b0;
    end
`endif

    // Main sequencer: all outputs are registered here
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= S_LOAD;
            r_index      <= '0;
            r_class      <= '0;
            r_digit_sent <= 1'b0;
            Mem_we       <= 1'b0;
            Mem_addr     <= '0;
            Mem_wdata    <= '0;
            Infer_start  <= 1'b0;
            Tx_start     <= 1'b0;
            Tx_byte      <= 8'h00;
            Busy         <= 1'b0;
            Overrun      <= 1'b0;
            Frame_count  <= '0;
        end else begin
            Mem_we      <= 1'b0;
            Infer_start <= 1'b0;
            Tx_start    <= 1'b0;

            // A number arriving outside LOAD is dropped and flagged
            if (Num_valid && (r_state != S_LOAD)) begin
                Overrun <= 1'b1;
            end

            case (r_state)
                S_LOAD: begin
                    if (Num_valid) begin
                        Mem_we    <= 1'b1;
                        Mem_addr  <= r_index;
                        Mem_wdata <= Num_data;
                        if (r_index == c_LAST_IDX) begin
                            r_index <= '0;
                            r_state <= S_START;
                            Busy    <= 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_index <= '0;
                    end
                end
                S_START: begin
                    Infer_start <= 1'b1;
                    r_state     <= S_WAIT_INFER;
                end
                S_WAIT_INFER: begin
                    if (Infer_done) begin
                        r_class      <= Infer_class;
                        Frame_count  <= Frame_count + 16'd1;
                        r_digit_sent <= 1'b0;
                        r_state      <= S_TX_DIGIT;
                    end
                end
                S_TX_DIGIT: begin
                    // First cycle launches the digit; Tx_done only counts afterwards
                    if (!r_digit_sent) begin
                        Tx_start     <= 1'b1;
                        Tx_byte      <= w_digit;
                        r_digit_sent <= 1'b1;
                    end else if (Tx_done) begin
                        Tx_start <= 1'b1;
                        Tx_byte  <= c_ASCII_LF;
                        r_state  <= S_TX_LF;
                    end
                end
                S_TX_LF: begin
                    if (Tx_done) begin
                        r_state <= S_LOAD;
                        Busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_index <= '0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecg_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecg_frame_sequencer
//  Description : Scoreboard bench for ecg_frame_sequencer with a 4-sample
//                frame, 4-bit class and a 10-cycle idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ecg_frame_sequencer;

    localparam int c_NS  = 4;
    localparam int c_TMO = 10;

    logic        Clk;
    logic        Rst;
    logic        Num_valid;
    logic [15:0] Num_data;
    logic        Mem_we;
    logic [7:0]  Mem_addr;
    logic [15:0] Mem_wdata;
    logic        Infer_start;
    logic        Infer_done;
    logic [3:0]  Infer_class;
    logic        Tx_start;
    logic [7:0]  Tx_byte;
    logic        Tx_done;
    logic        Busy;
    logic        Overrun;
    logic [15:0] Frame_count;

    ecg_frame_sequencer #(
        .DATA_W(16), .NUM_SAMPLES(c_NS), .ADDR_W(8), .CLASS_W(4), .TIMEOUT_CYCLES(c_TMO)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Num_valid(Num_valid), .Num_data(Num_data),
        .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
        .Infer_start(Infer_start), .Infer_done(Infer_done), .Infer_class(Infer_class),
        .Tx_start(Tx_start), .Tx_byte(Tx_byte), .Tx_done(Tx_done),
        .Busy(Busy), .Overrun(Overrun), .Frame_count(Frame_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;

    // reference model state
    int          m_idx     = 0;
    bit          m_busy    = 0;
    bit          m_overrun = 0;
    int          m_starts  = 0;
    logic [15:0] m_frames  = 0;
    bit          prev_last_wr = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: compare every write / tx launch against the scoreboard
    always @(negedge Clk) begin
        if (!Rst) begin
            if (Mem_we) begin
                if (wr_q.size() == 0) begin
                    check_val("wr_unexpected", 32'(Mem_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check_val("wr_addr", 32'(Mem_addr), 32'(e.addr));
                    check_val("wr_data", 32'(Mem_wdata), 32'(e.data));
                end
            end
            if (Tx_start) begin
                if (tx_q.size() == 0) begin
                    check_val("tx_unexpected", 32'(Tx_byte), 32'hFFFF_FFFF);
                end else begin
                    check_val("tx_byte", 32'(Tx_byte), 32'(tx_q.pop_front()));
                end
            end
            if (Infer_start) begin
                n_starts++;
                check_val("start_after_last_wr", 32'(prev_last_wr), 32'd1);
            end
            prev_last_wr = Mem_we && (Mem_addr == 8'(c_NS - 1));
        end else begin
            prev_last_wr = 0;
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send_num(input logic [15:0] v);
        wr_t e;
        if (m_busy) begin
            m_overrun = 1;
        end else begin
            e.addr = 8'(m_idx);
            e.data = v;
            wr_q.push_back(e);
            if (m_idx == c_NS - 1) begin
                m_idx  = 0;
                m_busy = 1;
                m_starts++;
            end else begin
                m_idx++;
            end
        end
        Num_valid = 1'b1;
        Num_data  = v;
        @(posedge Clk);
        #1;
        Num_valid = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 200 && n_starts < m_starts; i++) begin
            @(posedge Clk);
            #1;
        end
        check_val("infer_start_count", 32'(n_starts), 32'(m_starts));
    endtask

    task automatic wait_tx(input string tag);
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Tx_start) begin
                seen = 1;
                break;
            end
        end
        @(posedge Clk);
        #1;
        check_val(tag, 32'(seen), 32'd1);
    endtask

    task automatic pulse_tx_done();
        Tx_done = 1'b1;
        @(posedge Clk);
        #1;
        Tx_done = 1'b0;
    endtask

    task automatic finish_infer(input logic [3:0] cls);
        idle(2);
        tx_q.push_back((cls > 4'd9) ? 8'h3F : (8'h30 + 8'(cls)));
        Infer_class = cls;
        Infer_done  = 1'b1;
        @(posedge Clk);
        #1;
        Infer_done = 1'b0;
        m_frames++;
        check_val("frame_count", 32'(Frame_count), 32'(m_frames));
        wait_tx("tx_digit_seen");
        idle(3);
        tx_q.push_back(8'h0A);
        pulse_tx_done();
        wait_tx("tx_lf_seen");
        idle(3);
        pulse_tx_done();
        m_busy = 0;
        check_val("busy_after_lf", 32'(Busy), 32'd0);
    endtask

    initial begin
        logic [15:0] vals[4];
        vals[0] = 16'd5; vals[1] = 16'hFFFD; vals[2] = 16'd100; vals[3] = 16'h7FFF;
        Rst = 1'b1; Num_valid = 0; Num_data = 0; Infer_done = 0; Infer_class = 0; Tx_done = 0;
        idle(3);
        check_val("rst_mem_we", 32'(Mem_we), 0);
        check_val("rst_busy", 32'(Busy), 0);
        check_val("rst_overrun", 32'(Overrun), 0);
        check_val("rst_frame_count", 32'(Frame_count), 0);
        check_val("rst_tx_byte", 32'(Tx_byte), 0);
        check_val("rst_mem_addr", 32'(Mem_addr), 0);
        Rst = 1'b0;
        idle(2);

        // Frame 1: spaced samples, class 2
        for (int i = 0; i < 4; i++) begin
            send_num(vals[i]);
            idle(19);
        end
        wait_start();
        check_val("busy_wait_infer", 32'(Busy), 1);
        finish_infer(4'd2);
        check_val("overrun_clear", 32'(Overrun), 0);

        // Stray Tx_done in LOAD must be ignored
        idle(2);
        pulse_tx_done();
        idle(3);
        check_val("busy_after_stray_done", 32'(Busy), 0);

        // Frame 2: overrun during WAIT_INFER
        for (int i = 0; i < 4; i++) begin
            send_num(16'(i * 7 + 1));
            idle(1);
        end
        wait_start();
        send_num(16'd77);
        check_val("overrun_set", 32'(Overrun), 32'(m_overrun));
        finish_infer(4'd9);

        // Frame 3 starts in the re-entry cycle; class 12 reports '?'
        for (int i = 0; i < 4; i++) send_num(16'h8000 + 16'(i));
        wait_start();
        finish_infer(4'd12);
        check_val("overrun_sticky", 32'(Overrun), 1);

        // Asynchronous reset mid-frame
        idle(2);
        send_num(16'h1111);
        send_num(16'h2222);
        idle(1);
        #3;
        Rst = 1'b1;
        #1;
        check_val("async_rst_addr", 32'(Mem_addr), 0);
        check_val("async_rst_wdata", 32'(Mem_wdata), 0);
        check_val("async_rst_overrun", 32'(Overrun), 0);
        check_val("async_rst_frames", 32'(Frame_count), 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        m_idx = 0; m_busy = 0; m_overrun = 0; m_frames = 0;
        idle(2);
        for (int i = 0; i < 3; i++) send_num(16'h0100 + 16'(i));
        idle(3);
        check_val("no_start_early", 32'(n_starts), 32'(m_starts));
        send_num(16'h0103);
        wait_start();
        finish_infer(4'd7);

        // Idle gap inside a partial frame
        idle(2);
        send_num(16'hAAAA);
        send_num(16'hBBBB);
        idle(c_TMO);
`ifdef LOAD_TIMEOUT_EN
        m_idx = 0;
`endif
        send_num(16'hCCCC);
        while (!m_busy) send_num(16'hDDDD);
        wait_start();
        finish_infer(4'd0);

        idle(5);
        check_val("wr_q_empty", 32'(wr_q.size()), 0);
        check_val("tx_q_empty", 32'(tx_q.size()), 0);
        check_val("start_total", 32'(n_starts), 32'(m_starts));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
